// File: rtl/insn_prefetch_pkg.sv
// Shared definitions for the instruction prefetcher.
// - prefetch_state_t : FSM state encoding for insn_prefetch.
// - RESET_CS_DEF / RESET_IP_DEF : default CS:IP loaded at reset.
// - word_addr() : 19-bit word address of the 20-bit physical address CS:IP.
package insn_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } prefetch_state_t;

  localparam logic [15:0] RESET_CS_DEF = 16'hFFFF;
  localparam logic [15:0] RESET_IP_DEF = 16'h0000;

  // ({cs,4'b0} + ip) >> 1 equals {cs,3'b0} + ip[15:1] because {cs,4'b0} is even.
  // The 19-bit sum drops the carry, giving the 1MB wrap.
  function automatic logic [18:0] word_addr(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, 3'b000} + {4'b0000, ip[15:1]};
  endfunction

endpackage

// File: rtl/insn_prefetch_buffer.sv
// Two-byte holding register between the memory bus and the instruction FIFO.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   clear            drop all held bytes (has priority over load/pop)
//   load, load_two   capture a fetched word: both bytes, or only the odd byte [15:8]
//   load_data        16-bit memory word, little endian
//   pop              discard the head byte (low address first)
//   head             byte to push next
//   valid_cnt        number of bytes held (0..2)
module insn_prefetch_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        load_two,
  input  logic [15:0] load_data,
  input  logic        pop,
  output logic [7:0]  head,
  output logic [1:0]  valid_cnt
);

  logic [7:0] byte0_q, byte0_d;
  logic [7:0] byte1_q, byte1_d;
  logic [1:0] cnt_q,   cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    byte0_d = byte0_q;
    byte1_d = byte1_q;
    cnt_d   = cnt_q;
    if (clear) begin
      byte0_d = 8'h00;
      byte1_d = 8'h00;
      cnt_d   = 2'd0;
    end else if (load) begin
      if (load_two) begin
        byte0_d = load_data[7:0];
        byte1_d = load_data[15:8];
        cnt_d   = 2'd2;
      end else begin
        byte0_d = load_data[15:8];
        byte1_d = 8'h00;
        cnt_d   = 2'd1;
      end
    end else if (pop && (cnt_q != 2'd0)) begin
      byte0_d = byte1_q;
      byte1_d = 8'h00;
      cnt_d   = cnt_q - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte0_q <= 8'h00;
      byte1_q <= 8'h00;
      cnt_q   <= 2'd0;
    end else begin
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head      = byte0_q;
  assign valid_cnt = cnt_q;

endmodule

// File: rtl/insn_prefetch.sv
// Instruction prefetcher: fetches 16-bit words at CS:IP and pushes them into the
// instruction byte FIFO one byte per cycle; redirects and flushes on a branch.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   load_new_ip, new_cs, new_ip redirect pulse and target CS:IP
//   fifo_wr_en, fifo_wr_data    byte push into the instruction FIFO
//   fifo_full                   FIFO back-pressure
//   fifo_reset                  FIFO flush, same cycle as load_new_ip
//   mem_address, mem_access     word read request, held until mem_ack
//   mem_ack, mem_data           read completion and data
module insn_prefetch
  import insn_prefetch_pkg::*;
#(
  parameter logic [15:0] RESET_CS = RESET_CS_DEF,
  parameter logic [15:0] RESET_IP = RESET_IP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  input  logic        fifo_full,
  output logic        fifo_reset,
  output logic [18:0] mem_address,
  output logic        mem_access,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  prefetch_state_t state_q, state_d;
  logic [15:0]     cs_q, cs_d;
  logic [15:0]     ip_q, ip_d;
  // Address of the outstanding read; frozen so a redirect during the read
  // does not disturb the bus while cs/ip already hold the new target.
  logic [18:0]     req_addr_q, req_addr_d;

  logic       buf_clear, buf_load, buf_load_two, buf_pop;
  logic [7:0] buf_head;
  logic [1:0] buf_cnt;

  insn_prefetch_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .clear     (buf_clear),
    .load      (buf_load),
    .load_two  (buf_load_two),
    .load_data (mem_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .valid_cnt (buf_cnt)
  );

  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    ip_d         = ip_q;
    req_addr_d   = req_addr_q;
    buf_clear    = 1'b0;
    buf_load     = 1'b0;
    buf_load_two = 1'b0;
    buf_pop      = 1'b0;
    fifo_wr_en   = 1'b0;
    mem_access   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!load_new_ip) begin
          state_d    = FETCH;
          req_addr_d = word_addr(cs_q, ip_q);
        end
      end
      FETCH: begin
        mem_access = 1'b1;
        if (load_new_ip) begin
          // An ack coinciding with the redirect completes the bus cycle; its data is dropped.
          state_d = mem_ack ? IDLE : ABORT;
        end else if (mem_ack) begin
          buf_load     = 1'b1;
          buf_load_two = ~ip_q[0];
          // An odd IP takes only the high byte, which re-aligns all later fetches.
          ip_d         = ip_q + (ip_q[0] ? 16'd1 : 16'd2);
          state_d      = DRAIN;
        end
      end
      ABORT: begin
        mem_access = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (load_new_ip) begin
          state_d = IDLE;
        end else if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          buf_pop    = 1'b1;
          if (buf_cnt <= 2'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_new_ip) begin
      cs_d      = new_cs;
      ip_d      = new_ip;
      buf_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cs_q       <= RESET_CS;
      ip_q       <= RESET_IP;
      req_addr_q <= 19'h0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      ip_q       <= ip_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign fifo_reset   = load_new_ip;
  assign fifo_wr_data = fifo_wr_en ? buf_head : 8'h00;
  assign mem_address  = mem_access ? req_addr_q : 19'h0;

endmodule

// File: tb/tb_insn_prefetch.sv
module tb_insn_prefetch;

  logic        clk;
  logic        reset;
  logic        load_new_ip;
  logic [15:0] new_cs;
  logic [15:0] new_ip;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full;
  logic        fifo_reset;
  logic [18:0] mem_address;
  logic        mem_access;
  logic        mem_ack;
  logic [15:0] mem_data;

  insn_prefetch dut (
    .clk          (clk),
    .reset        (reset),
    .load_new_ip  (load_new_ip),
    .new_cs       (new_cs),
    .new_ip       (new_ip),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_reset   (fifo_reset),
    .mem_address  (mem_address),
    .mem_access   (mem_access),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_fifo_reset = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  typedef struct {
    logic [15:0] cs;
    logic [15:0] ip;
    logic [15:0] data;
    int          delay;
    logic [18:0] exp_addr;
    int          n;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [18:0] exp_next;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Push scoreboard: every byte written to the FIFO must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_reset) n_fifo_reset++;
      if (fifo_wr_en && fifo_full) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_while_full: wr_en=1 with fifo_full=1");
      end
      if (fifo_wr_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL push_unexpected: got byte %02h, expected no push", fifo_wr_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (fifo_wr_data !== exp_b) begin
            n_fail++;
            $display("FAIL push_data: got %02h, expected %02h", fifo_wr_data, exp_b);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at a negedge where mem_access is high.
  task automatic wait_req(input string name, input logic [18:0] exp_addr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mem_access) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no request in 20 cycles, expected address %05h", name, exp_addr);
    end else begin
      check(name, {13'h0, mem_address}, {13'h0, exp_addr});
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    #1;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d bytes still expected, expected 0", name, exp_q.size());
    end
  endtask

  // Called #1 after a posedge; one-cycle redirect pulse, optionally with a coincident ack.
  task automatic redirect(input logic [15:0] cs, input logic [15:0] ip, input logic with_ack);
    load_new_ip = 1'b1;
    new_cs      = cs;
    new_ip      = ip;
    mem_ack     = with_ack;
    mem_data    = 16'hDEAD;
    @(negedge clk);
    check("redirect_fifo_reset", {31'h0, fifo_reset}, 32'h1);
    check("redirect_no_push", {31'h0, fifo_wr_en}, 32'h0);
    step();
    load_new_ip = 1'b0;
    mem_ack     = 1'b0;
    mem_data    = 16'h0000;
  endtask

  // Called #1 after a posedge; ack lasts one cycle, then checks first-push latency.
  task automatic ack(input logic [15:0] data);
    mem_ack  = 1'b1;
    mem_data = data;
    step();
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    @(negedge clk);
    check("latency_push", {31'h0, fifo_wr_en}, 32'h1);
  endtask

  initial begin
    int fr_before;

    vecs[0] = '{16'h0000, 16'h0101, 16'h3412, 1, 19'h00080, 1, 8'h34, 8'h00, 19'h00081};
    vecs[1] = '{16'h1000, 16'hFFFE, 16'h2211, 0, 19'h0FFFF, 2, 8'h11, 8'h22, 19'h08000};
    vecs[2] = '{16'hFFFF, 16'hFFF0, 16'hA55A, 3, 19'h07FF0, 2, 8'h5A, 8'hA5, 19'h07FF1};
    vecs[3] = '{16'h1234, 16'h5679, 16'hC3B2, 2, 19'h0BCDC, 1, 8'hC3, 8'h00, 19'h0BCDD};
    vecs[4] = '{16'h0000, 16'hFFFF, 16'h7F01, 0, 19'h07FFF, 1, 8'h7F, 8'h00, 19'h00000};

    reset       = 1'b1;
    load_new_ip = 1'b0;
    new_cs      = 16'h0;
    new_ip      = 16'h0;
    fifo_full   = 1'b0;
    mem_ack     = 1'b0;
    mem_data    = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_wr_en",   {31'h0, fifo_wr_en},   32'h0);
    check("reset_wr_data", {24'h0, fifo_wr_data}, 32'h0);
    check("reset_access",  {31'h0, mem_access},   32'h0);
    check("reset_address", {13'h0, mem_address},  32'h0);
    check("reset_fifo_reset", {31'h0, fifo_reset}, 32'h0);

    // First request in the 2nd cycle after reset release, at FFFF:0000
    step();
    reset = 1'b0;
    @(negedge clk);
    check("cycle1_idle", {31'h0, mem_access}, 32'h0);
    @(negedge clk);
    check("cycle2_access", {31'h0, mem_access}, 32'h1);
    check("cycle2_address", {13'h0, mem_address}, {13'h0, 19'h7FFF8});
    step();
    step();
    exp_q.push_back(8'h90);
    exp_q.push_back(8'hEA);
    ack(16'hEA90);
    wait_drain("drain_reset_word");
    wait_req("next_after_reset", 19'h7FFF9);

    // Table: redirect during FETCH with a coincident (dropped) ack, then one fetch
    foreach (vecs[k]) begin
      step();
      redirect(vecs[k].cs, vecs[k].ip, 1'b1);
      wait_req("vec_addr", vecs[k].exp_addr);
      step();
      repeat (vecs[k].delay) step();
      exp_q.push_back(vecs[k].b0);
      if (vecs[k].n == 2) exp_q.push_back(vecs[k].b1);
      ack(vecs[k].data);
      wait_drain("vec_drain");
      wait_req("vec_next", vecs[k].exp_next);
    end

    // FIFO full for 5 cycles mid-DRAIN
    step();
    redirect(16'h0000, 16'h0200, 1'b1);
    wait_req("stall_addr", 19'h00100);
    step();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    ack(16'hBBAA);
    step();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_push", {31'h0, fifo_wr_en}, 32'h0);
      step();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check("stall_resume_push", {31'h0, fifo_wr_en}, 32'h1);
    wait_drain("stall_drain");
    wait_req("stall_next", 19'h00101);

    // Redirect during FETCH, ack 3 cycles later: address held, data discarded
    step();
    fr_before = n_fifo_reset;
    redirect(16'h0000, 16'h0400, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_access", {31'h0, mem_access}, 32'h1);
      check("abort_address", {13'h0, mem_address}, {13'h0, 19'h00101});
      step();
    end
    mem_ack  = 1'b1;
    mem_data = 16'hDEAD;
    @(negedge clk);
    check("abort_ack_address", {13'h0, mem_address}, {13'h0, 19'h00101});
    step();
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    wait_req("abort_next", 19'h00200);
    check("abort_fifo_reset_once", n_fifo_reset - fr_before, 32'h1);

    // Async reset in DRAIN with one byte still held
    step();
    exp_q.push_back(8'h66);
    ack(16'h7766);
    step();
    reset = 1'b1;
    #1;
    check("async_reset_access", {31'h0, mem_access}, 32'h0);
    check("async_reset_wr_en",  {31'h0, fifo_wr_en}, 32'h0);
    step();
    step();
    reset = 1'b0;
    wait_req("restart_addr", 19'h7FFF8);
    check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
